// File: rtl/led_colour_scheduler.sv
// led_colour_scheduler: round-robin sharing of one 3-bit RGB LED between N_REQ requesters.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low (0 = reset)
//   req         per-requester request level, held high until granted
//   req_colour  colour of requester i at [3i+2:3i]
//   req_hold    display length of requester i at [HOLD_W*i +: HOLD_W]
//   grant       one-hot, one-cycle pulse when a request is accepted
//   busy        high while a granted colour is being shown
//   done        one-cycle pulse on the last display cycle of a grant
//   colour      registered LED colour, always within 1..6
//
// With no request pending the LED steps 1..6 every IDLE_STEP cycles. A grant
// freezes that sequence; it resumes from the saved colour with a fresh step count.
module led_colour_scheduler #(
    parameter int N_REQ     = 3,
    parameter int HOLD_W    = 8,
    parameter int IDLE_STEP = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [3*N_REQ-1:0]      req_colour,
    input  logic [HOLD_W*N_REQ-1:0] req_hold,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    done,
    output logic [2:0]              colour
);
    localparam int PW = $clog2(N_REQ);
    localparam int SW = (IDLE_STEP > 1) ? $clog2(IDLE_STEP) : 1;

    typedef enum logic {IDLE, SHOW} state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     step_q, step_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [2:0]        idle_colour_q, idle_colour_d;
    logic [2:0]        colour_q, colour_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              found;
    logic [PW-1:0]     win;
    logic [PW:0]       idx;
    logic [2:0]        win_colour, show_colour, next_idle;
    logic [HOLD_W-1:0] win_hold, show_hold;
    logic [PW-1:0]     next_ptr;
    logic              wrap, last_show, take;

    // Circular search starting at the pointer; the first set request wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx >= (PW+1)'(N_REQ)) idx = idx - (PW+1)'(N_REQ);
            if (!found && req[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        win_colour = '0;
        win_hold   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == PW'(i)) begin
                win_colour = req_colour[3*i +: 3];
                win_hold   = req_hold[HOLD_W*i +: HOLD_W];
            end
        end
    end

    // Off (0) and white (7) must never reach the LED pins.
    assign show_colour = (win_colour == 3'd0) ? 3'd1 : (win_colour == 3'd7) ? 3'd6 : win_colour;
    assign show_hold   = (win_hold == '0) ? HOLD_W'(1) : win_hold;
    assign next_ptr    = (win == PW'(N_REQ-1)) ? '0 : win + 1'b1;
    assign next_idle   = (idle_colour_q == 3'd6) ? 3'd1 : idle_colour_q + 3'd1;
    assign wrap        = step_q == SW'(IDLE_STEP-1);
    assign last_show   = (state_q == SHOW) && (hold_q == HOLD_W'(1));
    // A grant in the final SHOW cycle chains straight into the next display.
    assign take        = found && ((state_q == IDLE) || last_show);

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        hold_d        = hold_q;
        ptr_d         = ptr_q;
        idle_colour_d = idle_colour_q;
        colour_d      = colour_q;
        grant_d       = '0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        if (take) begin
            state_d  = SHOW;
            grant_d  = N_REQ'(1) << win;
            busy_d   = 1'b1;
            colour_d = show_colour;
            hold_d   = show_hold;
            done_d   = show_hold == HOLD_W'(1);
            ptr_d    = next_ptr;
        end else if (state_q == IDLE) begin
            step_d        = wrap ? '0 : step_q + 1'b1;
            idle_colour_d = wrap ? next_idle : idle_colour_q;
            colour_d      = wrap ? next_idle : colour_q;
        end else if (last_show) begin
            state_d  = IDLE;
            step_d   = '0;
            busy_d   = 1'b0;
            colour_d = idle_colour_q;
        end else begin
            hold_d = hold_q - 1'b1;
            done_d = hold_q == HOLD_W'(2);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            step_q        <= '0;
            hold_q        <= '0;
            ptr_q         <= '0;
            idle_colour_q <= 3'd1;
            colour_q      <= 3'd1;
            grant_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            hold_q        <= hold_d;
            ptr_q         <= ptr_d;
            idle_colour_q <= idle_colour_d;
            colour_q      <= colour_d;
            grant_q       <= grant_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign grant  = grant_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign colour = colour_q;
endmodule

// File: tb/tb_led_colour_scheduler.sv
// tb_led_colour_scheduler: self-checking bench for led_colour_scheduler.
module tb_led_colour_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req = '0;
    logic [8:0]  req_colour = '0;
    logic [23:0] req_hold = '0;
    logic [2:0]  grant;
    logic        busy, done;
    logic [2:0]  colour;

    always #5 clk = ~clk;

    led_colour_scheduler #(.N_REQ(3), .HOLD_W(8), .IDLE_STEP(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_colour(req_colour), .req_hold(req_hold),
        .grant(grant), .busy(busy), .done(done), .colour(colour)
    );

    typedef struct { logic [2:0] g; logic [2:0] c; int h; } exp_t;
    typedef struct { logic [2:0] r; logic [8:0] col; logic [23:0] hold; exp_t e; } vec_t;

    exp_t sb[$];
    exp_t cur;
    int   rem = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t vt[6];
    int   rr_c[8] = '{2, 2, 3, 3, 4, 4, 2, 2};
    int   rr_g[8] = '{1, 0, 2, 0, 4, 0, 1, 0};
    int   c0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: each grant pops the expected record, then the whole
    // display window is checked cycle by cycle; outside it the LED must idle.
    always @(negedge clk) begin
        if (!rst) begin
            rem = 0;
            sb.delete();
        end else begin
            if (grant != 3'b000) begin
                if (sb.size() == 0) chk("unexpected_grant", int'(grant), 0);
                else begin
                    cur = sb.pop_front();
                    chk("sb_grant", int'(grant), int'(cur.g));
                    chk("sb_grant_colour", int'(colour), int'(cur.c));
                    rem = cur.h;
                end
            end
            if (rem > 0) begin
                chk("sb_show_colour", int'(colour), int'(cur.c));
                chk("sb_show_busy", int'(busy), 1);
                chk("sb_show_done", int'(done), int'(rem == 1));
                rem--;
            end else begin
                chk("sb_idle_busy", int'(busy), 0);
                chk("sb_idle_done", int'(done), 0);
                chk("sb_idle_colour_legal", int'(colour inside {[1:6]}), 1);
            end
        end
    end

    task automatic wait_grant(input string name);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (grant == 3'b000 && t < 40);
        chk({name, "_grant_seen"}, int'(grant != 3'b000), 1);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_idle_reached"}, int'(busy), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        #1;
        chk("rst_colour", int'(colour), 1);
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{3'b001, {3'd3, 3'd3, 3'd0}, {8'd1, 8'd1, 8'd0}, '{3'b001, 3'd1, 1}};
        vt[1] = '{3'b101, {3'd7, 3'd2, 3'd3}, {8'd2, 8'd1, 8'd5}, '{3'b100, 3'd6, 2}};
        vt[2] = '{3'b110, {3'd4, 3'd5, 3'd1}, {8'd1, 8'd3, 8'd1}, '{3'b010, 3'd5, 3}};
        vt[3] = '{3'b011, {3'd1, 3'd2, 3'd6}, {8'd1, 8'd1, 8'd4}, '{3'b001, 3'd6, 4}};
        vt[4] = '{3'b010, {3'd1, 3'd0, 3'd1}, {8'd1, 8'd0, 8'd1}, '{3'b010, 3'd1, 1}};
        vt[5] = '{3'b100, {3'd1, 3'd1, 3'd1}, {8'd3, 8'd1, 8'd1}, '{3'b100, 3'd1, 3}};

        repeat (2) @(negedge clk);
        chk("por_colour", int'(colour), 1);
        chk("por_busy", int'(busy), 0);
        chk("por_grant", int'(grant), 0);
        rst = 1'b1;

        for (int n = 1; n <= 28; n++) begin
            @(negedge clk);
            chk("idle_seq_colour", int'(colour), ((n / 4) % 6) + 1);
            chk("idle_seq_grant", int'(grant), 0);
        end

        c0 = int'(colour);
        req_colour = {3'd0, 3'd5, 3'd0};
        req_hold   = {8'd0, 8'd3, 8'd0};
        sb.push_back('{3'b010, 3'd5, 3});
        req = 3'b010;
        wait_grant("single");
        req = '0;
        chk("single_grant", int'(grant), 2);
        chk("single_colour", int'(colour), 5);
        repeat (2) @(negedge clk);
        chk("single_done", int'(done), 1);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("single_resume_colour", int'(colour), c0);
            chk("single_resume_busy", int'(busy), 0);
        end
        @(negedge clk);
        chk("single_resume_step", int'(colour), (c0 == 6) ? 1 : c0 + 1);

        do_reset();
        req_colour = {3'd4, 3'd3, 3'd2};
        req_hold   = {8'd2, 8'd2, 8'd2};
        sb.push_back('{3'b001, 3'd2, 2});
        sb.push_back('{3'b010, 3'd3, 2});
        sb.push_back('{3'b100, 3'd4, 2});
        sb.push_back('{3'b001, 3'd2, 2});
        req = 3'b111;
        wait_grant("rr");
        for (int n = 0; n < 8; n++) begin
            if (n > 0) @(negedge clk);
            chk("rr_colour", int'(colour), rr_c[n]);
            chk("rr_grant", int'(grant), rr_g[n]);
            chk("rr_busy", int'(busy), 1);
            if (n == 6) req = '0;
        end
        wait_idle("rr");

        do_reset();
        for (int v = 0; v < 6; v++) begin
            wait_idle("vec");
            req_colour = vt[v].col;
            req_hold   = vt[v].hold;
            sb.push_back(vt[v].e);
            req = vt[v].r;
            wait_grant("vec");
            req = '0;
            chk("vec_grant", int'(grant), int'(vt[v].e.g));
            chk("vec_colour", int'(colour), int'(vt[v].e.c));
        end
        wait_idle("vec_end");

        do_reset();
        req_colour = {3'd5, 3'd0, 3'd2};
        req_hold   = {8'd2, 8'd0, 8'd6};
        sb.push_back('{3'b001, 3'd2, 6});
        req = 3'b001;
        wait_grant("late");
        req = '0;
        @(negedge clk);
        sb.push_back('{3'b100, 3'd5, 2});
        req = 3'b100;
        for (int n = 2; n <= 6; n++) begin
            if (n > 2) @(negedge clk);
            chk("late_no_grant", int'(grant), 0);
            chk("late_colour", int'(colour), 2);
        end
        @(negedge clk);
        req = '0;
        chk("late_grant", int'(grant), 4);
        chk("late_new_colour", int'(colour), 5);
        chk("late_busy", int'(busy), 1);
        wait_idle("late");

        do_reset();
        req_colour = {3'd6, 3'd3, 3'd4};
        req_hold   = {8'd1, 8'd10, 8'd1};
        sb.push_back('{3'b010, 3'd3, 10});
        req = 3'b010;
        wait_grant("abort");
        req = '0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_colour", int'(colour), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_grant", int'(grant), 0);
        chk("abort_done", int'(done), 0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", int'(done), 0);
        end
        rst = 1'b1;
        sb.push_back('{3'b010, 3'd3, 10});
        req = 3'b110;
        wait_grant("abort_ptr");
        req = '0;
        chk("abort_ptr_grant", int'(grant), 2);
        wait_idle("abort_ptr");

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
